// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, state/owner encodings and helpers for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADR_W  = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LAT_W  = 4;
    localparam int unsigned STV_W  = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
    typedef enum logic [1:0] {NONE, OWN_I, OWN_D} arb_owner_t;

    // Selects the 32-bit instruction word out of a 64-bit memory beat.
    function automatic logic [31:0] fetch_word(input logic [DATA_W-1:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADR_W-1:0]  if_adr;
    logic              if_flush;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADR_W-1:0]  d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_stall;
    logic              m_req;
    logic              m_we;
    logic [ADR_W-1:0]  m_adr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  if_req, if_adr, if_flush, d_req, d_we, d_adr, d_wdata, m_rdata,
        output if_rdata, if_done, if_stall, d_rdata, d_done, mem_stall,
               m_req, m_we, m_adr, m_wdata
    );

    modport master (
        output if_req, if_adr, if_flush, d_req, d_we, d_adr, d_wdata, m_rdata,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, mem_stall,
               m_req, m_we, m_adr, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module arb_lat_counter #(
    parameter int unsigned   W       = 4,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF and MEM stages, data-first priority.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state;
    arb_owner_t owner;
    logic       bubble;
    logic       drop;
    logic       sel_hi;
    logic       is_store;
    logic       lat_zero;
    logic       grant_ok;
    logic       grant_d;
    logic       grant_i;
    logic       fetch_drop;

    // The done cycle is the mandatory bubble, so a still-held request is not re-granted.
    assign grant_ok   = (state == IDLE) && !bubble;
    assign fetch_drop = bus.if_flush || !bus.if_req;

    arb_lat_counter #(
        .W       (LAT_W),
        .RST_VAL ('0)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ISSUE),
        .load_val (LAT_W'(MEM_LAT - 1)),
        .dec      (state == WAIT),
        .zero     (lat_zero)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic starve_zero;
    logic force_i;

    // Counts down the data grants still allowed while a fetch waits.
    arb_lat_counter #(
        .W       (STV_W),
        .RST_VAL (STV_W'(STARVE_MAX))
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_ok && (grant_i || (grant_d && !bus.if_req))),
        .load_val (STV_W'(STARVE_MAX)),
        .dec      (grant_ok && grant_d && bus.if_req),
        .zero     (starve_zero)
    );

    assign force_i = starve_zero && bus.if_req;
    assign grant_d = bus.d_req && !force_i;
    assign grant_i = bus.if_req && (!bus.d_req || force_i);
`else
    assign grant_d = bus.d_req;
    assign grant_i = bus.if_req && !bus.d_req;
`endif

    assign bus.if_stall  = rst && bus.if_req && !bus.if_done;
    assign bus.mem_stall = rst && bus.d_req && !bus.d_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= NONE;
            bubble       <= 1'b0;
            drop         <= 1'b0;
            sel_hi       <= 1'b0;
            is_store     <= 1'b0;
            bus.m_req    <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_adr    <= '0;
            bus.m_wdata  <= '0;
            bus.if_rdata <= '0;
            bus.if_done  <= 1'b0;
            bus.d_rdata  <= '0;
            bus.d_done   <= 1'b0;
        end else begin
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.if_done <= 1'b0;
            bus.d_done  <= 1'b0;
            bubble      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_ok && grant_d) begin
                        owner       <= OWN_D;
                        state       <= ISSUE;
                        is_store    <= bus.d_we;
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.d_we;
                        bus.m_adr   <= bus.d_adr;
                        bus.m_wdata <= bus.d_wdata;
                    end else if (grant_ok && grant_i) begin
                        owner       <= OWN_I;
                        state       <= ISSUE;
                        is_store    <= 1'b0;
                        sel_hi      <= bus.if_adr[2];
                        drop        <= bus.if_flush;
                        bus.m_req   <= 1'b1;
                        bus.m_adr   <= bus.if_adr;
                        bus.m_wdata <= '0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    if ((owner == OWN_I) && fetch_drop) drop <= 1'b1;
                end
                WAIT: begin
                    if (lat_zero) begin
                        state  <= IDLE;
                        owner  <= NONE;
                        bubble <= 1'b1;
                        drop   <= 1'b0;
                        if (owner == OWN_D) begin
                            bus.d_done <= 1'b1;
                            if (!is_store) bus.d_rdata <= bus.m_rdata;
                        end else if ((owner == OWN_I) && !drop && !fetch_drop) begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= fetch_word(bus.m_rdata, sel_hi);
                        end
                    end else if ((owner == OWN_I) && fetch_drop) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus flush, reset and grant-pattern sequences.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MEM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [63:0] ia;
        logic        fl;
        logic        dr;
        logic        we;
        logic [63:0] da;
        logic [63:0] dw;
        logic [63:0] mr;
        logic        e_mreq;
        logic        e_mwe;
        logic [63:0] e_madr;
        logic [63:0] e_mwd;
        logic        e_idone;
        logic [31:0] e_ird;
        logic        e_ddone;
        logic [63:0] e_drd;
        logic        e_is;
        logic        e_ms;
    } vec_t;

    localparam logic        T  = 1'b1;
    localparam logic        F  = 1'b0;
    localparam logic [63:0] Z  = '0;
    localparam logic [31:0] IA = 32'hAAAA_BBBB;
    localparam logic [31:0] IB = 32'h7777_8888;
    localparam logic [63:0] DL = 64'h1111_2222_3333_4444;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.if_req   = 1'b0;
        bus.if_adr   = '0;
        bus.if_flush = 1'b0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_adr    = '0;
        bus.d_wdata  = '0;
        bus.m_rdata  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bit({tag, "_m_req"}, bus.m_req, 1'b0);
        chk_bit({tag, "_m_we"}, bus.m_we, 1'b0);
        chk({tag, "_m_adr"}, bus.m_adr, Z);
        chk({tag, "_m_wdata"}, bus.m_wdata, Z);
        chk({tag, "_if_rdata"}, 64'(bus.if_rdata), Z);
        chk_bit({tag, "_if_done"}, bus.if_done, 1'b0);
        chk_bit({tag, "_if_stall"}, bus.if_stall, 1'b0);
        chk({tag, "_d_rdata"}, bus.d_rdata, Z);
        chk_bit({tag, "_d_done"}, bus.d_done, 1'b0);
        chk_bit({tag, "_mem_stall"}, bus.mem_stall, 1'b0);
    endtask

    logic [63:0] exp_g [10];
    int          n_grant;

    initial begin
        // Fetch only, then load racing a fetch, then a store.
        vecs[0]  = '{T,64'h4,F,F,F,Z,Z,Z,                     T,F,64'h4,Z,F,32'h0,F,Z,T,F};
        vecs[1]  = '{T,64'h4,F,F,F,Z,Z,Z,                     F,F,Z,Z,F,32'h0,F,Z,T,F};
        vecs[2]  = '{T,64'h4,F,F,F,Z,Z,Z,                     F,F,Z,Z,F,32'h0,F,Z,T,F};
        vecs[3]  = '{T,64'h4,F,F,F,Z,Z,64'hAAAA_BBBB_0000_0013, F,F,Z,Z,T,IA,F,Z,F,F};
        vecs[4]  = '{F,Z,F,F,F,Z,Z,Z,                         F,F,Z,Z,F,IA,F,Z,F,F};
        vecs[5]  = '{T,64'h8,F,T,F,64'h40,Z,Z,                T,F,64'h40,Z,F,IA,F,Z,T,T};
        vecs[6]  = '{T,64'h8,F,T,F,64'h40,Z,Z,                F,F,Z,Z,F,IA,F,Z,T,T};
        vecs[7]  = '{T,64'h8,F,T,F,64'h40,Z,Z,                F,F,Z,Z,F,IA,F,Z,T,T};
        vecs[8]  = '{T,64'h8,F,T,F,64'h40,Z,DL,               F,F,Z,Z,F,IA,T,DL,T,F};
        vecs[9]  = '{T,64'h8,F,F,F,Z,Z,Z,                     F,F,Z,Z,F,IA,F,DL,T,F};
        vecs[10] = '{T,64'h8,F,F,F,Z,Z,Z,                     T,F,64'h8,Z,F,IA,F,DL,T,F};
        vecs[11] = '{T,64'h8,F,F,F,Z,Z,Z,                     F,F,Z,Z,F,IA,F,DL,T,F};
        vecs[12] = '{T,64'h8,F,F,F,Z,Z,Z,                     F,F,Z,Z,F,IA,F,DL,T,F};
        vecs[13] = '{T,64'h8,F,F,F,Z,Z,64'h5555_6666_7777_8888, F,F,Z,Z,T,IB,F,DL,F,F};
        vecs[14] = '{F,Z,F,F,F,Z,Z,Z,                         F,F,Z,Z,F,IB,F,DL,F,F};
        vecs[15] = '{F,Z,F,T,T,64'h80,64'h1234,Z,             T,T,64'h80,64'h1234,F,IB,F,DL,F,T};
        vecs[16] = '{F,Z,F,T,T,64'h80,64'h1234,Z,             F,F,Z,Z,F,IB,F,DL,F,T};
        vecs[17] = '{F,Z,F,T,T,64'h80,64'h1234,Z,             F,F,Z,Z,F,IB,F,DL,F,T};
        vecs[18] = '{F,Z,F,T,T,64'h80,64'h1234,64'hDEAD_BEEF_DEAD_BEEF, F,F,Z,Z,F,IB,T,DL,F,F};
        vecs[19] = '{F,Z,F,F,F,Z,Z,Z,                         F,F,Z,Z,F,IB,F,DL,F,F};

        drive_idle();
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        #1 rst = 1'b0;
        #1 chk_all_zero("reset0");
        drive_idle();
        #1 rst = 1'b1;

        foreach (vecs[i]) begin
            bus.if_req   = vecs[i].ir;
            bus.if_adr   = vecs[i].ia;
            bus.if_flush = vecs[i].fl;
            bus.d_req    = vecs[i].dr;
            bus.d_we     = vecs[i].we;
            bus.d_adr    = vecs[i].da;
            bus.d_wdata  = vecs[i].dw;
            bus.m_rdata  = vecs[i].mr;
            step();
            chk_bit($sformatf("r%0d_m_req", i), bus.m_req, vecs[i].e_mreq);
            chk_bit($sformatf("r%0d_m_we", i), bus.m_we, vecs[i].e_mwe);
            if (vecs[i].e_mreq) chk($sformatf("r%0d_m_adr", i), bus.m_adr, vecs[i].e_madr);
            if (vecs[i].e_mwe) chk($sformatf("r%0d_m_wdata", i), bus.m_wdata, vecs[i].e_mwd);
            chk_bit($sformatf("r%0d_if_done", i), bus.if_done, vecs[i].e_idone);
            chk($sformatf("r%0d_if_rdata", i), 64'(bus.if_rdata), 64'(vecs[i].e_ird));
            chk_bit($sformatf("r%0d_d_done", i), bus.d_done, vecs[i].e_ddone);
            chk($sformatf("r%0d_d_rdata", i), bus.d_rdata, vecs[i].e_drd);
            chk_bit($sformatf("r%0d_if_stall", i), bus.if_stall, vecs[i].e_is);
            chk_bit($sformatf("r%0d_mem_stall", i), bus.mem_stall, vecs[i].e_ms);
        end

        // Flush during WAIT: access runs out, if_done suppressed, next fetch after the bubble.
        drive_idle();
        bus.if_req = 1'b1;
        bus.if_adr = 64'h10;
        step();
        chk_bit("flush_grant_m_req", bus.m_req, 1'b1);
        chk("flush_grant_m_adr", bus.m_adr, 64'h10);
        step();
        bus.if_flush = 1'b1;
        step();
        chk_bit("flush_wait_if_done", bus.if_done, 1'b0);
        bus.if_flush = 1'b0;
        bus.if_adr   = 64'h20;
        bus.m_rdata  = 64'hCAFE_CAFE_CAFE_CAFE;
        step();
        chk_bit("flush_end_if_done", bus.if_done, 1'b0);
        chk("flush_end_if_rdata", 64'(bus.if_rdata), 64'(IB));
        chk_bit("flush_end_if_stall", bus.if_stall, 1'b1);
        bus.m_rdata = '0;
        step();
        chk_bit("flush_bubble_m_req", bus.m_req, 1'b0);
        step();
        chk_bit("refetch_m_req", bus.m_req, 1'b1);
        chk("refetch_m_adr", bus.m_adr, 64'h20);
        step();
        step();
        bus.m_rdata = 64'h0BAD_F00D_1357_9BDF;
        step();
        chk_bit("refetch_if_done", bus.if_done, 1'b1);
        chk("refetch_if_rdata", 64'(bus.if_rdata), 64'h1357_9BDF);
        drive_idle();
        step();

        // Asynchronous reset in WAIT of a load; held d_req restarts from IDLE.
        bus.d_req = 1'b1;
        bus.d_adr = 64'h100;
        step();
        chk_bit("rst_pre_m_req", bus.m_req, 1'b1);
        step();
        bus.if_req = 1'b1;
        #3 rst = 1'b0;
        #1 chk_all_zero("reset_mid");
        #2;
        rst = 1'b1;
        bus.if_req = 1'b0;
        step();
        chk_bit("rst_restart_m_req", bus.m_req, 1'b1);
        chk("rst_restart_m_adr", bus.m_adr, 64'h100);
        step();
        step();
        bus.m_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        chk_bit("rst_restart_d_done", bus.d_done, 1'b1);
        chk("rst_restart_d_rdata", bus.d_rdata, 64'h0123_4567_89AB_CDEF);
        drive_idle();
        step();

        // Both requests held continuously: record grant order from m_adr.
        for (int g = 0; g < 10; g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_g[g] = ((g % 5) == 4) ? 64'h300 : 64'h200;
`else
            exp_g[g] = 64'h200;
`endif
        end
        bus.d_req  = 1'b1;
        bus.d_adr  = 64'h200;
        bus.if_req = 1'b1;
        bus.if_adr = 64'h300;
        n_grant = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.m_req) begin
                if (n_grant < 10) chk($sformatf("grant%0d_m_adr", n_grant), bus.m_adr, exp_g[n_grant]);
                n_grant++;
            end
        end
        chk("grant_count", 64'(n_grant), 64'd10);
        drive_idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
